// File: rtl/id_ex_pipeline_register_pkg.sv
// Shared definitions for the ID/EX pipeline register: control bundle layout,
// ALU opcodes, addressing modes and the bubble encoding.
package id_ex_pipeline_register_pkg;

  localparam int unsigned CTRL_W       = 14;
  localparam int unsigned REG_IDX_W    = 4;
  localparam int unsigned COND_W       = 4;
  localparam int unsigned SHIFTER_W    = 12;
  localparam int unsigned BUBBLE_CNT_W = 16;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,  ALU_EOR = 4'd1,  ALU_SUB = 4'd2,  ALU_RSB = 4'd3,
    ALU_ADD = 4'd4,  ALU_ADC = 4'd5,  ALU_SBC = 4'd6,  ALU_RSC = 4'd7,
    ALU_TST = 4'd8,  ALU_TEQ = 4'd9,  ALU_CMP = 4'd10, ALU_CMN = 4'd11,
    ALU_ORR = 4'd12, ALU_MOV = 4'd13, ALU_BIC = 4'd14, ALU_MVN = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ADDR_IMM       = 2'd0,
    ADDR_REG       = 2'd1,
    ADDR_REG_SHIFT = 2'd2,
    ADDR_OFFSET    = 2'd3
  } addr_mode_e;

  // Field order fixes the bit positions: reg_write_enable is bit 13, addressing_mode is [1:0].
  typedef struct packed {
    logic       reg_write_enable;
    logic       mem_enable;
    logic       mem_rw;
    logic       mem_to_reg_select;
    logic       alu_source_select;
    logic       status_bit;
    alu_op_e    alu_operation;
    logic       pc_source_select;
    logic       mem_size;
    addr_mode_e addressing_mode;
  } ctrl_t;

  localparam logic [CTRL_W-1:0]       CTRL_BUBBLE    = '0;
  localparam logic [BUBBLE_CNT_W-1:0] BUBBLE_CNT_MAX = '1;

endpackage

// File: rtl/id_ex_pipeline_register_load_use_detector.sv
// Combinational load-use hazard compare between the load in EX and the
// instruction waiting in ID.
module load_use_detector
  import id_ex_pipeline_register_pkg::*;
(
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic                 ex_valid,
  input  logic                 ex_reg_write,
  input  logic                 ex_mem_enable,
  input  logic                 ex_mem_rw,
  input  logic                 ex_mem_to_reg,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic [REG_IDX_W-1:0] id_rn,
  input  logic [REG_IDX_W-1:0] id_rm,
  input  logic                 id_uses_rm,
  output logic                 load_use_stall
);

  logic ex_is_load;
  logic reg_match;

  // Rn is always compared, even when the ID instruction ignores it.
  always_comb begin
    ex_is_load     = ex_valid && ex_reg_write && ex_mem_enable && !ex_mem_rw && ex_mem_to_reg;
    reg_match      = (ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm));
    load_use_stall = !reset && !flush && id_valid && ex_is_load && reg_match;
  end

endmodule

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register with flush, hold, load-use bubble insertion and a
// saturating bubble counter.
module id_ex_pipeline_register
  import id_ex_pipeline_register_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [CTRL_W-1:0]       id_ctrl,
  input  logic [COND_W-1:0]       id_cond,
  input  logic [REG_IDX_W-1:0]    id_rn,
  input  logic [REG_IDX_W-1:0]    id_rm,
  input  logic                    id_uses_rm,
  input  logic [REG_IDX_W-1:0]    id_rd,
  input  logic [DATA_W-1:0]       id_rn_data,
  input  logic [DATA_W-1:0]       id_rm_data,
  input  logic [SHIFTER_W-1:0]    id_shifter,
  input  logic [DATA_W-1:0]       id_pc,
  input  logic                    ex_hold,
  input  logic                    flush,
  output logic                    ex_valid,
  output logic [CTRL_W-1:0]       ex_ctrl,
  output logic [COND_W-1:0]       ex_cond,
  output logic [REG_IDX_W-1:0]    ex_rn,
  output logic [REG_IDX_W-1:0]    ex_rm,
  output logic [REG_IDX_W-1:0]    ex_rd,
  output logic [DATA_W-1:0]       ex_rn_data,
  output logic [DATA_W-1:0]       ex_rm_data,
  output logic [DATA_W-1:0]       ex_pc,
  output logic [SHIFTER_W-1:0]    ex_shifter,
  output logic                    load_use_stall,
  output logic [BUBBLE_CNT_W-1:0] bubble_count
);

  ctrl_t                   ex_ctrl_q;
  logic                    update;
  logic                    take_id;
  logic                    stall_bubble;
  logic [BUBBLE_CNT_W-1:0] bubble_count_nxt;

  assign ex_ctrl = ex_ctrl_q;

  load_use_detector u_load_use_detector (
    .reset          (reset),
    .flush          (flush),
    .id_valid       (id_valid),
    .ex_valid       (ex_valid),
    .ex_reg_write   (ex_ctrl_q.reg_write_enable),
    .ex_mem_enable  (ex_ctrl_q.mem_enable),
    .ex_mem_rw      (ex_ctrl_q.mem_rw),
    .ex_mem_to_reg  (ex_ctrl_q.mem_to_reg_select),
    .ex_rd          (ex_rd),
    .id_rn          (id_rn),
    .id_rm          (id_rm),
    .id_uses_rm     (id_uses_rm),
    .load_use_stall (load_use_stall)
  );

  // Edge decode: flush beats hold, hold beats the load-use bubble.
  always_comb begin
    update           = flush || !ex_hold;
    take_id          = !flush && !ex_hold && !load_use_stall && id_valid;
    stall_bubble     = !flush && !ex_hold && load_use_stall;
    bubble_count_nxt = bubble_count;
    if (stall_bubble && (bubble_count != BUBBLE_CNT_MAX)) begin
      bubble_count_nxt = bubble_count + BUBBLE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_ctrl_q  <= ctrl_t'(CTRL_BUBBLE);
      ex_cond    <= '0;
      ex_rn      <= '0;
      ex_rm      <= '0;
      ex_rd      <= '0;
      ex_rn_data <= '0;
      ex_rm_data <= '0;
      ex_pc      <= '0;
      ex_shifter <= '0;
    end else if (update) begin
      if (take_id) begin
        ex_valid   <= 1'b1;
        ex_ctrl_q  <= ctrl_t'(id_ctrl);
        ex_cond    <= id_cond;
        ex_rn      <= id_rn;
        ex_rm      <= id_rm;
        ex_rd      <= id_rd;
        ex_rn_data <= id_rn_data;
        ex_rm_data <= id_rm_data;
        ex_pc      <= id_pc;
        ex_shifter <= id_shifter;
      end else begin
        ex_valid   <= 1'b0;
        ex_ctrl_q  <= ctrl_t'(CTRL_BUBBLE);
        ex_cond    <= '0;
        ex_rn      <= '0;
        ex_rm      <= '0;
        ex_rd      <= '0;
        ex_rn_data <= '0;
        ex_rm_data <= '0;
        ex_pc      <= '0;
        ex_shifter <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_count <= '0;
    end else begin
      bubble_count <= bubble_count_nxt;
    end
  end

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Directed scoreboard bench for id_ex_pipeline_register.
module tb_id_ex_pipeline_register;

  typedef struct packed {
    logic        valid;
    logic [13:0] ctrl;
    logic [3:0]  cond;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic        uses_rm;
    logic [3:0]  rd;
    logic [31:0] rn_data;
    logic [31:0] rm_data;
    logic [11:0] shifter;
    logic [31:0] pc;
  } id_vec_t;

  typedef struct packed {
    logic        valid;
    logic [13:0] ctrl;
    logic [3:0]  cond;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [3:0]  rd;
    logic [31:0] rn_data;
    logic [31:0] rm_data;
    logic [11:0] shifter;
    logic [31:0] pc;
    logic [15:0] bcnt;
  } ex_exp_t;

  localparam logic [13:0] C_LDR = 14'h3441;
  localparam logic [13:0] C_STR = 14'h1841;
  localparam logic [13:0] C_ADD = 14'h2041;
  localparam logic [13:0] C_MOV = 14'h20D0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [13:0] id_ctrl = '0;
  logic [3:0]  id_cond = '0, id_rn = '0, id_rm = '0, id_rd = '0;
  logic        id_uses_rm = 1'b0;
  logic [31:0] id_rn_data = '0, id_rm_data = '0, id_pc = '0;
  logic [11:0] id_shifter = '0;
  logic        ex_hold = 1'b0;
  logic        flush = 1'b0;
  logic        ex_valid;
  logic [13:0] ex_ctrl;
  logic [3:0]  ex_cond, ex_rn, ex_rm, ex_rd;
  logic [31:0] ex_rn_data, ex_rm_data, ex_pc;
  logic [11:0] ex_shifter;
  logic        load_use_stall;
  logic [15:0] bubble_count;

  int      n_checks = 0;
  int      n_fail = 0;
  ex_exp_t sb_q[$];
  ex_exp_t last_exp;

  always #5 clk = ~clk;

  id_ex_pipeline_register #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_cond(id_cond),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
    .id_rn_data(id_rn_data), .id_rm_data(id_rm_data), .id_shifter(id_shifter), .id_pc(id_pc),
    .ex_hold(ex_hold), .flush(flush), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_cond(ex_cond),
    .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd), .ex_rn_data(ex_rn_data), .ex_rm_data(ex_rm_data),
    .ex_pc(ex_pc), .ex_shifter(ex_shifter), .load_use_stall(load_use_stall), .bubble_count(bubble_count)
  );

  function automatic id_vec_t mk(input logic v, input logic [13:0] c, input logic [3:0] rd,
                                 input logic [3:0] rn, input logic [3:0] rm, input logic urm,
                                 input logic [31:0] pc);
    id_vec_t r;
    r.valid = v;        r.ctrl = c;                   r.cond = 4'hE;
    r.rn = rn;          r.rm = rm;                    r.uses_rm = urm;    r.rd = rd;
    r.rn_data = {28'hA5A5A5A, rn};  r.rm_data = {28'h5A5A5A5, rm};
    r.shifter = {8'h0C, rm};        r.pc = pc;
    return r;
  endfunction

  function automatic ex_exp_t exp_load(input id_vec_t v, input logic [15:0] cnt);
    ex_exp_t e;
    e.valid = 1'b1;   e.ctrl = v.ctrl;  e.cond = v.cond;  e.rn = v.rn;  e.rm = v.rm;
    e.rd = v.rd;      e.rn_data = v.rn_data;  e.rm_data = v.rm_data;
    e.shifter = v.shifter;  e.pc = v.pc;  e.bcnt = cnt;
    return e;
  endfunction

  function automatic ex_exp_t exp_bubble(input logic [15:0] cnt);
    ex_exp_t e = '0;
    e.bcnt = cnt;
    return e;
  endfunction

  // Drive one cycle's inputs at the falling edge, check the combinational stall,
  // queue what the outputs must be after the next rising edge.
  task automatic step(input id_vec_t v, input logic rst, input logic fl, input logic hold,
                      input logic exp_stall, input ex_exp_t exp);
    reset = rst;  flush = fl;  ex_hold = hold;
    id_valid = v.valid;  id_ctrl = v.ctrl;  id_cond = v.cond;  id_rn = v.rn;  id_rm = v.rm;
    id_uses_rm = v.uses_rm;  id_rd = v.rd;  id_rn_data = v.rn_data;  id_rm_data = v.rm_data;
    id_shifter = v.shifter;  id_pc = v.pc;
    #1;
    n_checks++;
    if (load_use_stall !== exp_stall) begin
      n_fail++;
      $display("FAIL stall @%0t: got %b want %b", $time, load_use_stall, exp_stall);
    end
    sb_q.push_back(exp);
    last_exp = exp;
    @(negedge clk);
  endtask

  // Monitor: registered outputs after each edge against the oldest expectation.
  always @(posedge clk) begin
    ex_exp_t e, a;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = '{ex_valid, ex_ctrl, ex_cond, ex_rn, ex_rm, ex_rd, ex_rn_data, ex_rm_data,
            ex_shifter, ex_pc, bubble_count};
      n_checks++;
      if ({a.valid, a.ctrl} !== {e.valid, e.ctrl}) begin
        n_fail++;
        $display("FAIL valid_ctrl @%0t: got %b/%h want %b/%h", $time, a.valid, a.ctrl, e.valid, e.ctrl);
      end
      n_checks++;
      if ({a.cond, a.rn, a.rm, a.rd, a.rn_data, a.rm_data, a.shifter, a.pc} !==
          {e.cond, e.rn, e.rm, e.rd, e.rn_data, e.rm_data, e.shifter, e.pc}) begin
        n_fail++;
        $display("FAIL fields @%0t: got %h %h %h %h %h %h %h %h want %h %h %h %h %h %h %h %h", $time,
                 a.cond, a.rn, a.rm, a.rd, a.rn_data, a.rm_data, a.shifter, a.pc,
                 e.cond, e.rn, e.rm, e.rd, e.rn_data, e.rm_data, e.shifter, e.pc);
      end
      n_checks++;
      if (a.bcnt !== e.bcnt) begin
        n_fail++;
        $display("FAIL bubble_count @%0t: got %h want %h", $time, a.bcnt, e.bcnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    id_vec_t ldr3, add1, str3, add4, ldr7, mov9, idle, nop, ldr10, add_rm10;
    logic [15:0] c;
    ldr3     = mk(1'b1, C_LDR, 4'd3,  4'd5,  4'd0,  1'b0, 32'h0000_0100);
    add1     = mk(1'b1, C_ADD, 4'd1,  4'd3,  4'd2,  1'b1, 32'h0000_0104);
    str3     = mk(1'b1, C_STR, 4'd3,  4'd6,  4'd0,  1'b0, 32'h0000_0200);
    add4     = mk(1'b1, C_ADD, 4'd4,  4'd3,  4'd3,  1'b1, 32'h0000_0204);
    ldr7     = mk(1'b1, C_LDR, 4'd7,  4'd8,  4'd0,  1'b0, 32'h0000_0208);
    mov9     = mk(1'b1, C_MOV, 4'd9,  4'd0,  4'd7,  1'b0, 32'h0000_020C);
    idle     = mk(1'b0, C_ADD, 4'd3,  4'd3,  4'd3,  1'b1, 32'h0000_0210);
    nop      = mk(1'b1, 14'h0, 4'd5,  4'd5,  4'd5,  1'b0, 32'h0000_0214);
    ldr10    = mk(1'b1, C_LDR, 4'd10, 4'd11, 4'd0,  1'b0, 32'h0000_0300);
    add_rm10 = mk(1'b1, C_ADD, 4'd2,  4'd0,  4'd10, 1'b1, 32'h0000_0304);
    @(negedge clk);

    // Reset, then first cycle after reset never stalls.
    step(ldr3, 1'b1, 1'b0, 1'b0, 1'b0, exp_bubble(16'd0));
    step(ldr3, 1'b1, 1'b0, 1'b0, 1'b0, exp_bubble(16'd0));
    step(ldr3, 1'b0, 1'b0, 1'b0, 1'b0, exp_load(ldr3, 16'd0));
    // Load-use on Rn: one bubble, then the ADD enters EX.
    step(add1, 1'b0, 1'b0, 1'b0, 1'b1, exp_bubble(16'd1));
    step(add1, 1'b0, 1'b0, 1'b0, 1'b0, exp_load(add1, 16'd1));
    // Store producing r3 is not a hazard.
    step(str3, 1'b0, 1'b0, 1'b0, 1'b0, exp_load(str3, 16'd1));
    step(add4, 1'b0, 1'b0, 1'b0, 1'b0, exp_load(add4, 16'd1));
    // Rm match ignored when the operand is an immediate.
    step(ldr7, 1'b0, 1'b0, 1'b0, 1'b0, exp_load(ldr7, 16'd1));
    step(mov9, 1'b0, 1'b0, 1'b0, 1'b0, exp_load(mov9, 16'd1));
    // Invalid ID gives a bubble; NOP loads as valid.
    step(idle, 1'b0, 1'b0, 1'b0, 1'b0, exp_bubble(16'd1));
    step(nop,  1'b0, 1'b0, 1'b0, 1'b0, exp_load(nop, 16'd1));
    // Flush overrides hold and hazard.
    step(ldr3, 1'b0, 1'b0, 1'b0, 1'b0, exp_load(ldr3, 16'd1));
    step(add1, 1'b0, 1'b1, 1'b1, 1'b0, exp_bubble(16'd1));
    // Hold for three cycles during a hazard, then exactly one bubble.
    step(ldr3, 1'b0, 1'b0, 1'b0, 1'b0, exp_load(ldr3, 16'd1));
    repeat (3) step(add1, 1'b0, 1'b0, 1'b1, 1'b1, last_exp);
    step(add1, 1'b0, 1'b0, 1'b0, 1'b1, exp_bubble(16'd2));
    step(add1, 1'b0, 1'b0, 1'b0, 1'b0, exp_load(add1, 16'd2));
    // Hazard through Rm.
    step(ldr10,    1'b0, 1'b0, 1'b0, 1'b0, exp_load(ldr10, 16'd2));
    step(add_rm10, 1'b0, 1'b0, 1'b0, 1'b1, exp_bubble(16'd3));
    step(add_rm10, 1'b0, 1'b0, 1'b0, 1'b0, exp_load(add_rm10, 16'd3));
    // Preload the counter near saturation.
    force dut.bubble_count = 16'hFFFE;
    step(idle, 1'b0, 1'b0, 1'b0, 1'b0, exp_bubble(16'hFFFE));
    release dut.bubble_count;
    for (int i = 0; i < 3; i++) begin
      c = (i == 0) ? 16'hFFFE : 16'hFFFF;
      step(ldr3, 1'b0, 1'b0, 1'b0, 1'b0, exp_load(ldr3, c));
      step(add1, 1'b0, 1'b0, 1'b0, 1'b1, exp_bubble(16'hFFFF));
      step(add1, 1'b0, 1'b0, 1'b0, 1'b0, exp_load(add1, 16'hFFFF));
    end
    // Reset while a hazard is pending discards the bubble.
    step(ldr3, 1'b0, 1'b0, 1'b0, 1'b0, exp_load(ldr3, 16'hFFFF));
    step(add1, 1'b1, 1'b0, 1'b0, 1'b0, exp_bubble(16'd0));
    step(add1, 1'b0, 1'b0, 1'b0, 1'b0, exp_load(add1, 16'd0));

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
